// File: rtl/ram_resp_pkg.sv
// Shared types and constants for the ram_responder slice: bus widths, channel
// FSM encoding, arbiter grant encoding and the registered response payload.
package ram_resp_pkg;

    localparam int unsigned DATA_W  = 64;
    localparam int unsigned IDX_W   = 64;
    localparam int unsigned N_CH    = 2;
    localparam int unsigned CH_INST = 0;
    localparam int unsigned CH_DATA = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } chan_state_t;

    typedef enum logic {
        PTR_INST = 1'b0,
        PTR_DATA = 1'b1
    } arb_ptr_t;

    // One-hot grant vector, bit CH_INST / CH_DATA
    typedef logic [N_CH-1:0] gnt_t;

    localparam gnt_t GNT_NONE = 2'b00;
    localparam gnt_t GNT_INST = 2'b01;
    localparam gnt_t GNT_DATA = 2'b10;

    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] rdata;
    } resp_t;

    function automatic arb_ptr_t ptr_flip(input arb_ptr_t p);
        return (p == PTR_INST) ? PTR_DATA : PTR_INST;
    endfunction

endpackage

// File: rtl/ram_resp_arb.sv
// Two-way round-robin arbiter. Availability for one channel depends only on the
// other channel's request, so a channel's ready never looks at its own valid.
module ram_resp_arb
    import ram_resp_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  gnt_t i_req,
    input  logic i_upd,
    output gnt_t o_avail_c,
    output gnt_t o_gnt_c
);

    arb_ptr_t r_ptr;

    // Pointer favours inst out of reset; flips only after a contested grant
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_ptr <= PTR_INST;
        end else if (i_upd) begin
            r_ptr <= ptr_flip(r_ptr);
        end
    end

    always_comb begin
        o_avail_c          = GNT_NONE;
        o_gnt_c            = GNT_NONE;
        o_avail_c[CH_INST] = !(i_req[CH_DATA] && (r_ptr == PTR_DATA));
        o_avail_c[CH_DATA] = !(i_req[CH_INST] && (r_ptr == PTR_INST));
        if (i_req[CH_INST] && o_avail_c[CH_INST]) begin
            o_gnt_c = GNT_INST;
        end else if (i_req[CH_DATA] && o_avail_c[CH_DATA]) begin
            o_gnt_c = GNT_DATA;
        end
    end

endmodule

// File: rtl/ram_responder.sv
// Dual-channel (inst read / data read-write) single-port RAM responder, latency 1.
// Define RAM_RESPONDER_ERR_EN to flag out-of-range indices instead of wrapping them.
module ram_responder
    import ram_resp_pkg::*;
#(
    parameter int unsigned DEPTH = 4096
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              inst_req_valid,
    output logic              inst_req_ready,
    input  logic [IDX_W-1:0]  inst_req_idx,
    output logic              inst_resp_valid,
    input  logic              inst_resp_ready,
    output logic [DATA_W-1:0] inst_resp_rdata,
    output logic              inst_resp_err,

    input  logic              data_req_valid,
    output logic              data_req_ready,
    input  logic [IDX_W-1:0]  data_req_idx,
    input  logic              data_req_wen,
    input  logic [DATA_W-1:0] data_req_wdata,
    input  logic [DATA_W-1:0] data_req_wmask,
    output logic              data_resp_valid,
    input  logic              data_resp_ready,
    output logic [DATA_W-1:0] data_resp_rdata,
    output logic              data_resp_err
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];

    chan_state_t r_inst_state;
    chan_state_t w_inst_state_nxt;
    chan_state_t r_data_state;
    chan_state_t w_data_state_nxt;
    resp_t       r_inst_resp;
    resp_t       r_data_resp;

    gnt_t              w_req;
    gnt_t              w_avail;
    gnt_t              w_gnt;
    logic              w_inst_free;
    logic              w_data_free;
    logic              w_inst_fire;
    logic              w_data_fire;
    logic              w_upd;
    logic              w_inst_err;
    logic              w_data_err;
    logic [AW-1:0]     w_inst_addr;
    logic [AW-1:0]     w_data_addr;
    logic [DATA_W-1:0] w_wr_word;

    assign w_inst_addr = inst_req_idx[AW-1:0];
    assign w_data_addr = data_req_idx[AW-1:0];

`ifdef RAM_RESPONDER_ERR_EN
    assign w_inst_err = |inst_req_idx[IDX_W-1:AW];
    assign w_data_err = |data_req_idx[IDX_W-1:AW];
`else
    // Upper index bits are ignored: indices wrap modulo DEPTH
    logic w_unused_idx;
    assign w_unused_idx = ^{inst_req_idx[IDX_W-1:AW], data_req_idx[IDX_W-1:AW]};
    assign w_inst_err   = 1'b0;
    assign w_data_err   = 1'b0;
`endif

    // A channel can take a new request when its response slot is empty or draining
    assign w_inst_free    = (r_inst_state == ST_IDLE) || inst_resp_ready;
    assign w_data_free    = (r_data_state == ST_IDLE) || data_resp_ready;
    assign w_req[CH_INST] = reset && inst_req_valid && w_inst_free;
    assign w_req[CH_DATA] = reset && data_req_valid && w_data_free;
    assign w_upd          = &w_req;
    assign w_inst_fire    = w_gnt[CH_INST];
    assign w_data_fire    = w_gnt[CH_DATA];

    ram_resp_arb u_arb (
        .clock     (clock),
        .reset     (reset),
        .i_req     (w_req),
        .i_upd     (w_upd),
        .o_avail_c (w_avail),
        .o_gnt_c   (w_gnt)
    );

    // Channel FSM state registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_inst_state <= ST_IDLE;
            r_data_state <= ST_IDLE;
        end else begin
            r_inst_state <= w_inst_state_nxt;
            r_data_state <= w_data_state_nxt;
        end
    end

    // Channel FSM next state: an accept always (re)fills the response slot
    always_comb begin
        w_inst_state_nxt = r_inst_state;
        w_data_state_nxt = r_data_state;
        case (r_inst_state)
            ST_IDLE: if (w_inst_fire) w_inst_state_nxt = ST_RESP;
            ST_RESP: if (inst_resp_ready && !w_inst_fire) w_inst_state_nxt = ST_IDLE;
            default: w_inst_state_nxt = ST_IDLE;
        endcase
        case (r_data_state)
            ST_IDLE: if (w_data_fire) w_data_state_nxt = ST_RESP;
            ST_RESP: if (data_resp_ready && !w_data_fire) w_data_state_nxt = ST_IDLE;
            default: w_data_state_nxt = ST_IDLE;
        endcase
    end

    // Channel outputs
    always_comb begin
        inst_req_ready  = reset && w_avail[CH_INST] && w_inst_free;
        data_req_ready  = reset && w_avail[CH_DATA] && w_data_free;
        inst_resp_valid = (r_inst_state == ST_RESP);
        data_resp_valid = (r_data_state == ST_RESP);
        inst_resp_rdata = r_inst_resp.rdata;
        inst_resp_err   = r_inst_resp.err;
        data_resp_rdata = r_data_resp.rdata;
        data_resp_err   = r_data_resp.err;
        w_wr_word       = (r_mem[w_data_addr] & ~data_req_wmask) |
                          (data_req_wdata & data_req_wmask);
    end

    // Response payloads captured at the accept edge, held until the next accept
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_inst_resp <= '0;
            r_data_resp <= '0;
        end else begin
            if (w_inst_fire) begin
                r_inst_resp.err   <= w_inst_err;
                r_inst_resp.rdata <= w_inst_err ? '0 : r_mem[w_inst_addr];
            end
            if (w_data_fire) begin
                r_data_resp.err   <= w_data_err;
                r_data_resp.rdata <= (w_data_err || data_req_wen) ? '0 : r_mem[w_data_addr];
            end
        end
    end

    // Array is never cleared by reset
    always_ff @(posedge clock) begin
        if (w_data_fire && data_req_wen && !w_data_err) begin
            r_mem[w_data_addr] <= w_wr_word;
        end
    end

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder: drivers push expected responses at accept,
// separate monitors pop and compare on every response handshake.
module tb_ram_responder;

    localparam int unsigned TB_DEPTH = 16;

    localparam logic [63:0] P0  = 64'h0000_0000_0000_A0A0;
    localparam logic [63:0] P1  = 64'h1111_1111_1111_1111;
    localparam logic [63:0] P2  = 64'h2222_2222_2222_2222;
    localparam logic [63:0] P3  = 64'h3333_3333_3333_3333;
    localparam logic [63:0] P15 = 64'hFFFF_0000_FFFF_0015;

    logic        clock = 1'b0;
    logic        reset;
    logic        inst_req_valid, inst_req_ready;
    logic [63:0] inst_req_idx;
    logic        inst_resp_valid, inst_resp_ready;
    logic [63:0] inst_resp_rdata;
    logic        inst_resp_err;
    logic        data_req_valid, data_req_ready;
    logic [63:0] data_req_idx;
    logic        data_req_wen;
    logic [63:0] data_req_wdata, data_req_wmask;
    logic        data_resp_valid, data_resp_ready;
    logic [63:0] data_resp_rdata;
    logic        data_resp_err;

    int n_checks = 0;
    int n_errs   = 0;

    logic [63:0] m_mem [TB_DEPTH];
    logic [64:0] q_inst [$];
    logic [64:0] q_data [$];
    logic [64:0] e_inst;
    logic [64:0] e_data;

    always #5 clock = ~clock;

    ram_responder #(.DEPTH(TB_DEPTH)) dut (
        .clock           (clock),
        .reset           (reset),
        .inst_req_valid  (inst_req_valid),
        .inst_req_ready  (inst_req_ready),
        .inst_req_idx    (inst_req_idx),
        .inst_resp_valid (inst_resp_valid),
        .inst_resp_ready (inst_resp_ready),
        .inst_resp_rdata (inst_resp_rdata),
        .inst_resp_err   (inst_resp_err),
        .data_req_valid  (data_req_valid),
        .data_req_ready  (data_req_ready),
        .data_req_idx    (data_req_idx),
        .data_req_wen    (data_req_wen),
        .data_req_wdata  (data_req_wdata),
        .data_req_wmask  (data_req_wmask),
        .data_resp_valid (data_resp_valid),
        .data_resp_ready (data_resp_ready),
        .data_resp_rdata (data_resp_rdata),
        .data_resp_err   (data_resp_err)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference model: returns {err, rdata} and applies writes to m_mem
    function automatic logic [64:0] model(input logic [63:0] idx, input logic wen,
                                          input logic [63:0] wd, input logic [63:0] wm);
        logic        err;
        int unsigned a;
`ifdef RAM_RESPONDER_ERR_EN
        err = (idx >= 64'(TB_DEPTH));
`else
        err = 1'b0;
`endif
        a = 32'(idx % 64'(TB_DEPTH));
        if (err) return {1'b1, 64'h0};
        if (wen) begin
            m_mem[a] = (m_mem[a] & ~wm) | (wd & wm);
            return {1'b0, 64'h0};
        end
        return {1'b0, m_mem[a]};
    endfunction

    task automatic data_op(input logic [63:0] idx, input logic wen, input logic [63:0] wd,
                           input logic [63:0] wm, input logic use_exp, input logic [64:0] exp_v);
        logic [64:0] mv;
        bit          done = 1'b0;
        data_req_idx   = idx;
        data_req_wen   = wen;
        data_req_wdata = wd;
        data_req_wmask = wm;
        data_req_valid = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clock);
            if (data_req_ready) begin
                mv = model(idx, wen, wd, wm);
                q_data.push_back(use_exp ? exp_v : mv);
                done = 1'b1;
            end
            @(posedge clock); #1;
        end
        data_req_valid = 1'b0;
        if (!done) begin
            n_checks++; n_errs++;
            $display("FAIL data_accept_timeout actual=no_accept required=accept idx=%0d", idx);
        end else begin
            check("data_resp_latency", 64'(data_resp_valid), 64'd1);
        end
    endtask

    task automatic inst_op(input logic [63:0] idx, input logic use_exp, input logic [64:0] exp_v);
        logic [64:0] mv;
        bit          done = 1'b0;
        inst_req_idx   = idx;
        inst_req_valid = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clock);
            if (inst_req_ready) begin
                mv = model(idx, 1'b0, 64'h0, 64'h0);
                q_inst.push_back(use_exp ? exp_v : mv);
                done = 1'b1;
            end
            @(posedge clock); #1;
        end
        inst_req_valid = 1'b0;
        if (!done) begin
            n_checks++; n_errs++;
            $display("FAIL inst_accept_timeout actual=no_accept required=accept idx=%0d", idx);
        end else begin
            check("inst_resp_latency", 64'(inst_resp_valid), 64'd1);
        end
    endtask

    // Inst response monitor
    always @(negedge clock) begin
        if (reset && inst_resp_valid && inst_resp_ready) begin
            if (q_inst.size() == 0) begin
                n_checks++; n_errs++;
                $display("FAIL inst_unexpected_resp actual=%h required=no_response", inst_resp_rdata);
            end else begin
                e_inst = q_inst.pop_front();
                check("inst_rdata", inst_resp_rdata, e_inst[63:0]);
                check("inst_err", 64'(inst_resp_err), 64'(e_inst[64]));
            end
        end
    end

    // Data response monitor
    always @(negedge clock) begin
        if (reset && data_resp_valid && data_resp_ready) begin
            if (q_data.size() == 0) begin
                n_checks++; n_errs++;
                $display("FAIL data_unexpected_resp actual=%h required=no_response", data_resp_rdata);
            end else begin
                e_data = q_data.pop_front();
                check("data_rdata", data_resp_rdata, e_data[63:0]);
                check("data_err", 64'(data_resp_err), 64'(e_data[64]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b0;
        inst_req_valid  = 1'b1;
        inst_req_idx    = 64'h0;
        inst_resp_ready = 1'b1;
        data_req_valid  = 1'b1;
        data_req_idx    = 64'h0;
        data_req_wen    = 1'b0;
        data_req_wdata  = 64'h0;
        data_req_wmask  = 64'h0;
        data_resp_ready = 1'b1;

        // Reset state, with requests pending to show ready is held low
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_inst_req_ready", 64'(inst_req_ready), 64'd0);
        check("rst_data_req_ready", 64'(data_req_ready), 64'd0);
        check("rst_inst_resp_valid", 64'(inst_resp_valid), 64'd0);
        check("rst_data_resp_valid", 64'(data_resp_valid), 64'd0);
        check("rst_inst_rdata", inst_resp_rdata, 64'h0);
        check("rst_data_rdata", data_resp_rdata, 64'h0);
        check("rst_errs", 64'({inst_resp_err, data_resp_err}), 64'd0);
        inst_req_valid = 1'b0;
        data_req_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;

        // Preload
        data_op(64'd0,  1'b1, P0,  '1, 1'b1, {1'b0, 64'h0});
        data_op(64'd1,  1'b1, P1,  '1, 1'b1, {1'b0, 64'h0});
        data_op(64'd2,  1'b1, P2,  '1, 1'b1, {1'b0, 64'h0});
        data_op(64'd3,  1'b1, P3,  '1, 1'b1, {1'b0, 64'h0});
        data_op(64'd15, 1'b1, P15, '1, 1'b1, {1'b0, 64'h0});

        // Full write then back-to-back read of the same index
        data_op(64'd5, 1'b1, 64'h1122334455667788, '1, 1'b0, '0);
        data_op(64'd5, 1'b0, 64'h0, 64'h0, 1'b1, {1'b0, 64'h1122334455667788});

        // Bit-masked write
        data_op(64'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, '1, 1'b0, '0);
        data_op(64'd5, 1'b1, 64'h0, 64'h0000_0000_FFFF_0000, 1'b0, '0);
        data_op(64'd5, 1'b0, 64'h0, 64'h0, 1'b1, {1'b0, 64'hFFFF_FFFF_0000_FFFF});
        inst_op(64'd5, 1'b1, {1'b0, 64'hFFFF_FFFF_0000_FFFF});
        data_op(64'd15, 1'b0, 64'h0, 64'h0, 1'b1, {1'b0, P15});

        // Contention: grants alternate inst, data, inst, data
        inst_req_idx   = 64'd1;
        inst_req_valid = 1'b1;
        data_req_idx   = 64'd2;
        data_req_wen   = 1'b0;
        data_req_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            check("arb_inst_ready", 64'(inst_req_ready), 64'((c % 2) == 0));
            check("arb_data_ready", 64'(data_req_ready), 64'((c % 2) == 1));
            if ((c % 2) == 0) q_inst.push_back({1'b0, P1});
            else              q_data.push_back({1'b0, P2});
            @(posedge clock); #1;
            check("arb_inst_resp_valid", 64'(inst_resp_valid), 64'((c % 2) == 0));
            check("arb_data_resp_valid", 64'(data_resp_valid), 64'((c % 2) == 1));
        end
        inst_req_valid = 1'b0;
        data_req_valid = 1'b0;
        @(posedge clock); #1;

        // Inst backpressure: response held, no new accept until resp_ready returns
        inst_resp_ready = 1'b0;
        inst_req_idx    = 64'd2;
        inst_req_valid  = 1'b1;
        @(negedge clock);
        check("bp_first_ready", 64'(inst_req_ready), 64'd1);
        q_inst.push_back({1'b0, P2});
        @(posedge clock); #1;
        inst_req_idx = 64'd1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            check("bp_req_ready", 64'(inst_req_ready), 64'd0);
            check("bp_resp_valid", 64'(inst_resp_valid), 64'd1);
            check("bp_rdata_stable", inst_resp_rdata, P2);
            @(posedge clock); #1;
        end
        inst_resp_ready = 1'b1;
        @(negedge clock);
        check("bp_ready_restored", 64'(inst_req_ready), 64'd1);
        q_inst.push_back({1'b0, P1});
        @(posedge clock); #1;
        inst_req_valid = 1'b0;
        check("bp_next_resp_valid", 64'(inst_resp_valid), 64'd1);
        @(posedge clock); #1;

        // Reset while a data write response is in flight
        data_resp_ready = 1'b0;
        data_req_idx    = 64'd7;
        data_req_wen    = 1'b1;
        data_req_wdata  = 64'h0BAD_F00D_CAFE_BEEF;
        data_req_wmask  = '1;
        data_req_valid  = 1'b1;
        @(negedge clock);
        check("mid_rst_accept_ready", 64'(data_req_ready), 64'd1);
        void'(model(64'd7, 1'b1, 64'h0BAD_F00D_CAFE_BEEF, '1));
        @(posedge clock); #1;
        data_req_valid = 1'b0;
        reset          = 1'b0;
        check("mid_rst_resp_pending", 64'(data_resp_valid), 64'd1);
        @(posedge clock); #1;
        check("mid_rst_resp_valid", 64'(data_resp_valid), 64'd0);
        check("mid_rst_rdata", data_resp_rdata, 64'h0);
        check("mid_rst_req_ready", 64'(data_req_ready), 64'd0);
        reset           = 1'b1;
        data_resp_ready = 1'b1;
        data_op(64'd7, 1'b0, 64'h0, 64'h0, 1'b1, {1'b0, 64'h0BAD_F00D_CAFE_BEEF});

        // Out-of-range index handling
`ifdef RAM_RESPONDER_ERR_EN
        data_op(64'(TB_DEPTH), 1'b0, 64'h0, 64'h0, 1'b1, {1'b1, 64'h0});
        inst_op(64'(TB_DEPTH), 1'b1, {1'b1, 64'h0});
        data_op(64'(TB_DEPTH + 3), 1'b1, 64'hDEAD_BEEF, '1, 1'b1, {1'b1, 64'h0});
        data_op(64'd3, 1'b0, 64'h0, 64'h0, 1'b1, {1'b0, P3});
`else
        data_op(64'(TB_DEPTH), 1'b0, 64'h0, 64'h0, 1'b1, {1'b0, P0});
        inst_op(64'(TB_DEPTH), 1'b1, {1'b0, P0});
        data_op(64'(TB_DEPTH + 3), 1'b1, 64'hDEAD_BEEF, '1, 1'b1, {1'b0, 64'h0});
        data_op(64'd3, 1'b0, 64'h0, 64'h0, 1'b1, {1'b0, 64'hDEAD_BEEF});
`endif

        for (int k = 0; k < 20 && (q_inst.size() != 0 || q_data.size() != 0); k++) begin
            @(posedge clock); #1;
        end
        check("drain_inst", 64'(q_inst.size()), 64'd0);
        check("drain_data", 64'(q_data.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/ram_responder.md
RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 4096, array size in 64-bit words, power of two >= 2.
REQ-002 SHALL have port clock  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  in  1  reset, synchronous, active-low.
REQ-004 SHALL have ports inst_req_valid in 1, inst_req_ready out 1, inst_req_idx in 64: instruction read request, word index.
REQ-005 SHALL have ports inst_resp_valid out 1, inst_resp_ready in 1, inst_resp_rdata out 64, inst_resp_err out 1.
REQ-006 SHALL have ports data_req_valid in 1, data_req_ready out 1, data_req_idx in 64, data_req_wen in 1, data_req_wdata in 64, data_req_wmask in 64 (bit-granular write mask).
REQ-007 SHALL have ports data_resp_valid out 1, data_resp_ready in 1, data_resp_rdata out 64, data_resp_err out 1.

Function
REQ-008 SHALL perform at most one array access (read or write) per cycle.
REQ-009 SHALL accept a request when req_valid and req_ready are both high at a rising edge.
REQ-010 SHALL drive channel req_ready = granted & (~resp_valid | resp_ready), combinationally; ready SHALL NOT depend on that channel's req_valid.
REQ-011 SHALL grant a lone valid channel immediately; on conflict (both valid, both able to accept) SHALL grant round-robin, pointer toggling only after a conflicted grant; pointer reset value = inst.
REQ-012 SHALL model each channel as FSM IDLE/RESP: IDLE->RESP on accept; RESP->IDLE on resp handshake without new accept; RESP->RESP on handshake plus same-cycle accept.
REQ-013 SHALL assert resp_valid exactly one cycle after acceptance (latency 1) and hold resp_valid and rdata/err stable until resp_ready.
REQ-014 SHALL, on data read, return array[idx] as of the accept edge.
REQ-015 SHALL, on data write, update array[idx] = (old & ~wmask) | (wdata & wmask) at the accept edge and respond with rdata = 0.
REQ-016 SHALL sustain one accepted request per cycle per channel when the other channel is idle and resp_ready stays high.
REQ-017 SHALL give a read accepted the cycle after a write to the same index the new data.

Reset
REQ-018 SHALL, while reset is low at an edge, clear both resp_valid, rdata, err to 0, both FSMs to IDLE, arbiter pointer to inst.
REQ-019 SHALL drive both req_ready low during reset; an in-flight response SHALL be discarded; array contents SHALL NOT be cleared.

Configuration
REQ-020 SHALL use macro RAM_RESPONDER_ERR_EN: defined -> idx >= DEPTH yields resp_err=1, rdata=0, write dropped; undefined -> idx taken modulo DEPTH, resp_err tied 0.

Structure
REQ-021 SHALL place DATA_W=64, IDX_W=64, channel FSM state encoding and grant encoding in shared package ram_resp_pkg.
REQ-022 SHALL implement arbitration in sub-module ram_resp_arb (2-way round-robin, one-hot grant, pointer update input).

Verification
REQ-023 SHALL cover: data write idx 5, wdata 0x1122334455667788, wmask all-ones; then data read idx 5 -> next-cycle data_resp_rdata 0x1122334455667788, err 0.
REQ-024 SHALL cover: preload idx 5 = 0xFFFF_FFFF_FFFF_FFFF, write wdata 0, wmask 0x0000_0000_FFFF_0000, read idx 5 -> 0xFFFF_FFFF_0000_FFFF.
REQ-025 SHALL cover: both channels valid every cycle for 4 cycles, resp_ready high -> grants alternate inst, data, inst, data; each resp_valid one cycle after its grant.
REQ-026 SHALL cover: inst_resp_ready low for 3 cycles after inst response -> rdata stable, inst_req_ready low, no new inst accept; ready restored in cycle resp_ready rises.
REQ-027 SHALL cover: reset low the cycle after data accept -> data_resp_valid 0 after reset edge, no response emitted; array write performed before reset remains readable.
REQ-028 SHALL cover: with RAM_RESPONDER_ERR_EN, read idx DEPTH -> err 1, rdata 0; without, read idx DEPTH -> array[0], err 0.
